// File: rtl/hitcount_seg_driver.sv
// Hit-counter display driver: double-dabble BCD conversion plus 4-digit multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled by defining HITCOUNT_SEG_LZB_EN.
module hitcount_seg_driver #(
  parameter int BIN_W        = 14,
  parameter int REFRESH_BITS = 17,
  parameter int SAT_VAL      = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] num,
  output logic [6:0]       led,
  output logic [3:0]       a
);

  localparam int ITER_W = $clog2(BIN_W + 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0]  SAT_LIM   = BIN_W'(SAT_VAL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [BIN_W-1:0]        bin_r;
  logic [BIN_W-1:0]        raw_r;
  logic [BIN_W-1:0]        last_num_r;
  logic [15:0]             acc_r;
  logic [15:0]             adj_s;
  logic [15:0]             bcd_disp_r;
  logic [ITER_W-1:0]       iter_r;
  logic                    start_s;

  logic [REFRESH_BITS-1:0] refresh_r;
  logic [1:0]              idx_r, idx_s;
  logic                    init_r;
  logic                    wrap_s, load_s, blank_s;
  logic [3:0]              digit_s;
  logic [6:0]              led_r, led_s;
  logic [3:0]              a_r, a_s;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = b[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [BIN_W-1:0] sat_clamp(input logic [BIN_W-1:0] v);
    logic [BIN_W-1:0] r;
    if (v > SAT_LIM) r = SAT_LIM;
    else             r = v;
    return r;
  endfunction

`ifdef HITCOUNT_SEG_LZB_EN
  // A digit is dark when it and every higher digit are zero; the ones digit always shows.
  function automatic logic lz_blank(input logic [15:0] b, input logic [1:0] idx);
    logic r;
    case (idx)
      2'd1:    r = (b[15:4]  == 12'h000);
      2'd2:    r = (b[15:8]  == 8'h00);
      2'd3:    r = (b[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  assign start_s = (num != last_num_r);
  assign adj_s   = bcd_adjust(acc_r);

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = SHIFT;
        else         state_s = IDLE;
      end
      SHIFT: begin
        if (iter_r == ITER_LAST) state_s = COMMIT;
        else                     state_s = SHIFT;
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Double-dabble datapath; the display register only ever takes a finished result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_r      <= '0;
      raw_r      <= '0;
      last_num_r <= '0;
      acc_r      <= 16'h0000;
      bcd_disp_r <= 16'h0000;
      iter_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            bin_r  <= sat_clamp(num);
            raw_r  <= num;
            acc_r  <= 16'h0000;
            iter_r <= '0;
          end
        end
        SHIFT: begin
          acc_r  <= {adj_s[14:0], bin_r[BIN_W-1]};
          bin_r  <= {bin_r[BIN_W-2:0], 1'b0};
          iter_r <= iter_r + ITER_W'(1);
        end
        COMMIT: begin
          // Raw value is recorded so a steady over-range input does not retrigger.
          bcd_disp_r <= acc_r;
          last_num_r <= raw_r;
        end
        default: iter_r <= '0;
      endcase
    end
  end

  // Next scan slot selection and its segment/anode pattern.
  always_comb begin
    wrap_s = &refresh_r;
    load_s = wrap_s | init_r;
    if (wrap_s) idx_s = idx_r + 2'd1;
    else        idx_s = idx_r;
    digit_s = bcd_disp_r[{idx_s, 2'b00} +: 4];
`ifdef HITCOUNT_SEG_LZB_EN
    blank_s = lz_blank(bcd_disp_r, idx_s);
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      led_s = 7'b1111111;
      a_s   = 4'b1111;
    end else begin
      led_s = seg_glyph(digit_s);
      a_s   = ~(4'b0001 << idx_s);
    end
  end

  // Scan counter and registered outputs; digit content is latched only at slot start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_r <= '0;
      idx_r     <= 2'd0;
      init_r    <= 1'b1;
      led_r     <= 7'b1111111;
      a_r       <= 4'b1111;
    end else begin
      refresh_r <= refresh_r + REFRESH_BITS'(1);
      init_r    <= 1'b0;
      if (load_s) begin
        idx_r <= idx_s;
        led_r <= led_s;
        a_r   <= a_s;
      end
    end
  end

  assign led = led_r;
  assign a   = a_r;

endmodule

// File: tb/tb_hitcount_seg_driver.sv
// Directed-vector bench for hitcount_seg_driver with a short refresh period.
// Leading-zero expectations follow HITCOUNT_SEG_LZB_EN when it is defined.
module tb_hitcount_seg_driver;

  logic        clk;
  logic        rst;
  logic [13:0] num;
  logic [6:0]  led;
  logic [3:0]  a;

  int n_checks = 0;
  int n_errors = 0;

  hitcount_seg_driver #(
    .BIN_W       (14),
    .REFRESH_BITS(2),
    .SAT_VAL     (9999)
  ) dut (
    .clk(clk),
    .rst(rst),
    .num(num),
    .led(led),
    .a  (a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int          busy_cycles;
  int          cnt_bad;
  int          cnt_lit;
  logic [15:0] exp_bcd;

  initial begin
    rst = 1'b0;
    num = 14'd1234;

    // Reset held for three edges: everything dark.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rst_led", 32'(led), 32'h7f);
      check_eq("rst_a", 32'(a), 32'hf);
    end

    // Release; 1234 is captured at E0 and commits at E15.
    rst = 1'b1;
    step(1);
    check_eq("post_rst_a", 32'(a), 32'b1110);
    check_eq("post_rst_led", 32'(led), 32'b1000000);
    check_eq("post_rst_bcd", 32'(dut.bcd_disp_r), 32'h0);
    step(14);
    check_eq("bcd_1234_early", 32'(dut.bcd_disp_r), 32'h0);
    step(1);
    check_eq("bcd_1234", 32'(dut.bcd_disp_r), 32'h1234);

    // Slots start at E19, E23, E27, E31 for digits 1,2,3,0.
    step(4);
    check_eq("scan1_a", 32'(a), 32'b1101);
    check_eq("scan1_led", 32'(led), 32'b0110000);
    step(4);
    check_eq("scan2_a", 32'(a), 32'b1011);
    check_eq("scan2_led", 32'(led), 32'b0100100);
    step(4);
    check_eq("scan3_a", 32'(a), 32'b0111);
    check_eq("scan3_led", 32'(led), 32'b1111001);
    step(4);
    check_eq("scan0_a", 32'(a), 32'b1110);
    check_eq("scan0_led", 32'(led), 32'b0011001);

    // Saturation: 16383 clamps to 9999 and a held value never retriggers.
    num = 14'd16383;
    step(16);
    check_eq("sat_bcd", 32'(dut.bcd_disp_r), 32'h9999);
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (dut.state_r != 2'd0) busy_cycles++;
    end
    check_eq("sat_no_retrigger", 32'(busy_cycles), 32'd0);
    check_eq("sat_bcd_hold", 32'(dut.bcd_disp_r), 32'h9999);

    // Mid-conversion change: 5 lands at F16, 77 at F32, nothing in between.
    num = 14'd5;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      if (i == 5) num = 14'd77;
      if (i < 16)      exp_bcd = 16'h9999;
      else if (i < 32) exp_bcd = 16'h0005;
      else             exp_bcd = 16'h0077;
      check_eq($sformatf("mid_bcd_%0d", i), 32'(dut.bcd_disp_r), 32'(exp_bcd));
    end

    // Reset during SHIFT aborts the conversion, then 999 converts afresh.
    num = 14'd999;
    step(7);
    rst = 1'b0;
    step(1);
    check_eq("abort_bcd", 32'(dut.bcd_disp_r), 32'h0);
    check_eq("abort_state", 32'(dut.state_r), 32'd0);
    check_eq("abort_a", 32'(a), 32'hf);
    check_eq("abort_led", 32'(led), 32'h7f);
    rst = 1'b1;
    step(1);
    check_eq("rerelease_a", 32'(a), 32'b1110);
    check_eq("rerelease_led", 32'(led), 32'b1000000);
    step(14);
    check_eq("bcd_999_early", 32'(dut.bcd_disp_r), 32'h0);
    step(1);
    check_eq("bcd_999", 32'(dut.bcd_disp_r), 32'h0999);

    // Value 42: observe two full frames once stale slots have drained.
    num = 14'd42;
    step(16);
    check_eq("bcd_42", 32'(dut.bcd_disp_r), 32'h0042);
    step(4);
    cnt_bad = 0;
    cnt_lit = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
`ifdef HITCOUNT_SEG_LZB_EN
      if (a[3] == 1'b0 || a[2] == 1'b0) cnt_bad++;
      if (a == 4'b1111 && led != 7'b1111111) cnt_bad++;
      if (a == 4'b1101 && led == 7'b0011001) cnt_lit++;
`else
      if (a != 4'b1110 && a != 4'b1101 && a != 4'b1011 && a != 4'b0111) cnt_bad++;
      if (a == 4'b0111 && led == 7'b1000000) cnt_lit++;
`endif
    end
    check_eq("d42_bad", 32'(cnt_bad), 32'd0);
    check_eq("d42_lit", 32'(cnt_lit != 0), 32'd1);

`ifdef HITCOUNT_SEG_LZB_EN
    // Zero: only the ones digit is lit, showing 0.
    num = 14'd0;
    step(20);
    cnt_bad = 0;
    cnt_lit = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (a != 4'b1110 && a != 4'b1111) cnt_bad++;
      if (a == 4'b1111 && led != 7'b1111111) cnt_bad++;
      if (a == 4'b1110 && led == 7'b1000000) cnt_lit++;
    end
    check_eq("zero_bad", 32'(cnt_bad), 32'd0);
    check_eq("zero_lit", 32'(cnt_lit), 32'd8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
